sync_frame: RTL and testbench

//  Receive-side frame synchronizer for the serial Hamming-encoded bit stream.
//  - Frame: SYNC_WORD header (MSB first), then FRAME_LEN-SW payload bits
//    (8 Hamming(7,4) codewords = 56 bits).
//  - Hunts for the header, confirms it on successive frames, declares lock, then flywheels over missed headers.
//  - Sits directly after the encoder's serial output, on the fast bit clock.

---
 rtl/sync_frame.sv | 138 +++++++++++++
 tb/tb_sync_frame.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_frame.sv
// rtl/sync_frame.sv - serial frame synchronizer: header hunt, confirm, lock, flywheel.
// Define FRAME_STROBE_EN to add the frame_start first-payload-bit strobe.
module sync_frame #(
   parameter int              SW        = 8,
   parameter logic [SW-1:0]   SYNC_WORD = 8'hA7,
   parameter int              FRAME_LEN = 64,
   parameter int              CONFIRM_N = 2,
   parameter int              LOSS_N    = 3
) (
   input  logic       clk_out,
   input  logic       rst,
   input  logic       data_in,
   output logic       is_frame_sychronized,
   output logic [2:0] synchronizer_state
`ifdef FRAME_STROBE_EN
   ,
   output logic       frame_start
`endif
);

   localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam int HW = $clog2(CONFIRM_N + 2);
   localparam int MW = $clog2(LOSS_N + 2);
   localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN - 1);
   localparam logic [HW-1:0] HITS_LOCK = HW'(CONFIRM_N);
   localparam logic [MW-1:0] MISS_LOSS = MW'(LOSS_N);

   typedef enum logic [2:0] {
      HUNT     = 3'd0,
      CONFIRM  = 3'd1,
      SYNC     = 3'd2,
      FLYWHEEL = 3'd3
   } state_e;

   state_e        state_q, state_d;
   // The oldest header bit never reaches the comparator a second time, so only
   // SW-1 bits of history are kept; the newest bit comes straight from data_in.
   logic [SW-2:0] sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hits_q, hits_d, hits_inc;
   logic [MW-1:0] miss_q, miss_d, miss_inc;
   logic [SW-1:0] window;
   logic          hit;
   logic          checkpoint;

   assign window     = {sr_q, data_in};
   assign hit        = (window == SYNC_WORD);
   assign checkpoint = (cnt_q == CNT_LAST);
   assign hits_inc   = hits_q + HW'(1);
   assign miss_inc   = miss_q + MW'(1);
   assign sr_d       = window[SW-2:0];

   always_comb begin
      state_d = state_q;
      hits_d  = hits_q;
      miss_d  = miss_q;
      cnt_d   = checkpoint ? '0 : cnt_q + CW'(1);
      case (state_q)
         HUNT: begin
            if (hit) begin
               state_d = CONFIRM;
               hits_d  = HW'(1);
               cnt_d   = '0;
            end
         end
         CONFIRM: begin
            if (checkpoint) begin
               if (hit) begin
                  hits_d = hits_inc;
                  if (hits_inc >= HITS_LOCK) state_d = SYNC;
               end else begin
                  state_d = HUNT;
               end
            end
         end
         SYNC: begin
            if (checkpoint) begin
               if (hit) begin
                  miss_d = '0;
               end else begin
                  miss_d  = MW'(1);
                  state_d = (MISS_LOSS <= MW'(1)) ? HUNT : FLYWHEEL;
               end
            end
         end
         FLYWHEEL: begin
            if (checkpoint) begin
               if (hit) begin
                  state_d = SYNC;
                  miss_d  = '0;
               end else begin
                  miss_d = miss_inc;
                  if (miss_inc >= MISS_LOSS) state_d = HUNT;
               end
            end
         end
         default: state_d = HUNT;
      endcase
      if (state_d == HUNT) begin
         hits_d = '0;
         miss_d = '0;
      end
   end

   always_ff @(posedge clk_out or negedge rst) begin
      if (!rst) begin
         state_q <= HUNT;
         sr_q    <= '0;
         cnt_q   <= '0;
         hits_q  <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         hits_q  <= hits_d;
         miss_q  <= miss_d;
      end
   end

   assign synchronizer_state   = state_q;
   assign is_frame_sychronized = (state_q == SYNC) || (state_q == FLYWHEEL);

`ifdef FRAME_STROBE_EN
   logic frame_start_q, frame_start_d;

   // Pulses with the first payload bit of every frame that is still held in lock.
   assign frame_start_d = checkpoint && ((state_d == SYNC) || (state_d == FLYWHEEL));

   always_ff @(posedge clk_out or negedge rst) begin
      if (!rst) frame_start_q <= 1'b0;
      else      frame_start_q <= frame_start_d;
   end

   assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_sync_frame.sv
// tb/tb_sync_frame.sv - randomized scoreboard bench for sync_frame against a bit-position model.
module tb_sync_frame;

   localparam int        FL        = 64;
   localparam int        CONFIRM_N = 2;
   localparam int        LOSS_N    = 3;
   localparam logic [7:0] SYNC     = 8'hA7;

   logic       clk_out = 1'b0;
   logic       rst     = 1'b0;
   logic       data_in = 1'b0;
   logic       is_frame_sychronized;
   logic [2:0] synchronizer_state;
`ifdef FRAME_STROBE_EN
   logic       frame_start;
`endif

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] exp_q[$];

   // Reference model: frames are located by absolute bit index relative to the
   // bit that ended the hunting hit, so checkpoints are simply multiples of FL.
   int         m_state, m_hits, m_miss, m_n, m_anchor;
   logic [7:0] m_win;

   sync_frame dut (
      .clk_out              (clk_out),
      .rst                  (rst),
      .data_in              (data_in),
      .is_frame_sychronized (is_frame_sychronized),
      .synchronizer_state   (synchronizer_state)
`ifdef FRAME_STROBE_EN
      ,
      .frame_start          (frame_start)
`endif
   );

   always #5 clk_out = ~clk_out;

   function automatic logic [3:0] enc(input int s);
      return {(s == 2 || s == 3), 3'(s)};
   endfunction

   function automatic logic [3:0] dut_out();
      return {is_frame_sychronized, synchronizer_state};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got {sync,state}=%h required %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state  = 0;
      m_hits   = 0;
      m_miss   = 0;
      m_n      = 0;
      m_anchor = 0;
      m_win    = 8'h00;
   endfunction

   function automatic void model_step(input bit b);
      bit hit;
      m_n++;
      m_win = {m_win[6:0], b};
      hit   = (m_win == SYNC);
      if (m_state == 0) begin
         if (hit) begin
            m_state  = 1;
            m_hits   = 1;
            m_anchor = m_n;
         end
      end else if ((m_n - m_anchor) % FL == 0) begin
         if (m_state == 1) begin
            if (hit) begin
               m_hits++;
               if (m_hits >= CONFIRM_N) m_state = 2;
            end else begin
               m_state = 0;
            end
         end else if (hit) begin
            m_state = 2;
            m_miss  = 0;
         end else begin
            m_miss++;
            m_state = (m_miss >= LOSS_N) ? 0 : 3;
         end
      end
      if (m_state == 0) begin
         m_hits = 0;
         m_miss = 0;
      end
   endfunction

   task automatic send_bit(input bit b, input bit r);
      @(negedge clk_out);
      rst     = r;
      data_in = b;
      if (!r) model_reset();
      else    model_step(b);
      exp_q.push_back(enc(m_state));
   endtask

   task automatic send_frame(input logic [7:0] hdr, input bit rnd, input int exp_state,
                             input string name);
      logic [7:0] h;
      h = hdr;
      for (int i = 7; i >= 0; i--) send_bit(h[i], 1'b1);
      if (exp_state >= 0) begin
         @(posedge clk_out);
         #1;
         check(name, dut_out(), enc(exp_state));
      end
      for (int i = 0; i < FL - 8; i++) send_bit(rnd ? 1'($urandom) : 1'b0, 1'b1);
   endtask

   initial begin : monitor
      logic [3:0] e;
      forever begin
         @(posedge clk_out);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", dut_out(), e);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [7:0] hdr;
      model_reset();
      #1;
      check("reset_async", dut_out(), 4'h0);
      send_bit(1'($urandom), 1'b0);
      send_bit(1'($urandom), 1'b0);

      send_frame(SYNC, 1'b0, 1, "lock_first_hdr");
      send_frame(SYNC, 1'b0, 2, "lock_second_hdr");

      send_frame(8'hA6, 1'b1, 3, "flywheel_enter");
      send_frame(SYNC, 1'b1, 2, "flywheel_recover");

      send_frame(8'h00, 1'b1, 3, "loss_miss1");
      send_frame(8'h00, 1'b1, 3, "loss_miss2");
      send_frame(8'h00, 1'b0, 0, "loss_miss3");

      send_frame(SYNC, 1'b0, 1, "false_hit");
      send_frame(8'h00, 1'b0, 0, "false_hit_drop");

      send_frame(SYNC, 1'b0, 1, "relock_first");
      send_frame(SYNC, 1'b0, 2, "relock_second");
      for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1'b1);
      @(posedge clk_out);
      #3;
      rst = 1'b0;
      #1;
      check("async_reset_mid_lock", dut_out(), 4'h0);
      send_bit(1'($urandom), 1'b0);
      send_bit(1'($urandom), 1'b0);
      send_frame(SYNC, 1'b0, 1, "after_reset_first");
      send_frame(SYNC, 1'b0, 2, "after_reset_second");

      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 5)) send_bit(1'($urandom), 1'b1);
         end
         hdr = ($urandom_range(0, 9) < 7) ? SYNC : 8'($urandom);
         send_frame(hdr, 1'b1, -1, "");
      end

      send_bit(1'b0, 1'b1);
      @(posedge clk_out);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
